// File: rtl/alu_gcd_ctrl_pkg.sv
// alu_gcd_ctrl_pkg: shared ALU operation codes and GCD controller state encoding
package alu_gcd_ctrl_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SHR = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SHL = 2'b11
  } alu_op_e;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_SUB_A = 3'd2,
    S_SUB_B = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/alu_gcd_ctrl_alu.sv
// alu_gcd_ctrl_alu: combinational ALU with add, subtract, shifts and an a>b flag
module alu_gcd_ctrl_alu
  import alu_gcd_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  alu_op_e        op_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [N-1:0]   q_o,
  output logic           mayor_o
);
  always_comb begin
    q_o = op_i == ALU_ADD ? a_i + b_i :
          op_i == ALU_SUB ? a_i - b_i :
          op_i == ALU_SHR ? a_i >> 1 : a_i << 1;
    mayor_o = a_i > b_i;
  end
endmodule

// File: rtl/alu_gcd_ctrl.sv
// alu_gcd_ctrl: subtractive GCD sequencer driving one shared ALU, one operation per cycle
module alu_gcd_ctrl
  import alu_gcd_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] q,
  output logic [N-1:0] o_iter
);
  state_e       state_q, state_d;
  logic [N-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, iter_q, iter_d;
  alu_op_e      alu_op;
  logic [N-1:0] alu_a, alu_b, alu_q;
  logic         alu_mayor;
  logic         finish;
  alu_gcd_ctrl_alu #(.N(N)) u_alu (
    .op_i   (alu_op),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .q_o    (alu_q),
    .mayor_o(alu_mayor)
  );
  always_comb begin
    alu_op = (state_q == S_SUB_A || state_q == S_SUB_B) ? ALU_SUB : ALU_ADD;
    alu_a  = state_q == S_SUB_B ? rb_q : ra_q;
    alu_b  = state_q == S_SUB_B ? ra_q : rb_q;
    finish = rb_q == '0 || ra_q == '0 || ra_q == rb_q;
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        ra_d    = i_a;
        rb_d    = i_b;
        iter_d  = '0;
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d = finish ? S_DONE : alu_mayor ? S_SUB_A : S_SUB_B;
        if (finish) res_d = (rb_q == '0 || ra_q == rb_q) ? ra_q : rb_q;
      end
      S_SUB_A: begin
        ra_d    = alu_q;
        iter_d  = &iter_q ? iter_q : iter_q + N'(1);
        state_d = S_CMP;
      end
      S_SUB_B: begin
        rb_d    = alu_q;
        iter_d  = &iter_q ? iter_q : iter_q + N'(1);
        state_d = S_CMP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      iter_q  <= iter_d;
    end
  end
  assign o_busy = state_q == S_CMP || state_q == S_SUB_A || state_q == S_SUB_B;
  assign o_done = state_q == S_DONE;
  assign q      = res_q;
  assign o_iter = iter_q;
endmodule

// File: doc/alu_gcd_ctrl.md
ALU_GCD_CTRL -- requirements
Module: alu_gcd_ctrl

Interface
REQ-001 Parameter N, default 16: operand, result and iteration-counter width.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  start request; sampled only while idle.
REQ-005 i_a  input  N  first operand, unsigned.
REQ-006 i_b  input  N  second operand, unsigned.
REQ-007 o_busy  output  1  high while a computation is in progress.
REQ-008 o_done  output  1  single-cycle pulse when the result is valid.
REQ-009 q  output  N  greatest common divisor of the last accepted operands.
REQ-010 o_iter  output  N  number of subtraction steps used by the last computation.

Function
REQ-011 The block SHALL compute gcd(a,b) by repeated subtraction, sequencing one shared alu instance, one ALU operation per cycle.
REQ-012 ALU codes SHALL be: 00 add/compare, 10 subtract, 01 shift right, 11 shift left; the block uses only 00 and 10.
REQ-013 The alu control input SHALL be driven with a defined code in every state; it is 00 with operands (ra,rb) unless stated otherwise.
REQ-014 FSM states SHALL be IDLE, CMP, SUB_A, SUB_B and DONE.
REQ-015 IDLE: i_start=1 SHALL load ra<=i_a, rb<=i_b and o_iter<=0, then enter CMP; i_start=0 keeps IDLE.
REQ-016 CMP: ALU code 00 with operands (ra,rb). Exit conditions in priority order:
- rb==0 -> DONE, q<=ra.
- ra==0 -> DONE, q<=rb.
- ra==rb -> DONE, q<=ra.
- ALU mayor=1 -> SUB_A.
- otherwise -> SUB_B.
REQ-017 SUB_A: ALU code 10 with operands (ra,rb); ra<=ALU q; o_iter increments; next state is CMP.
REQ-018 SUB_B: ALU code 10 with operands (rb,ra); rb<=ALU q; o_iter increments; next state is CMP.
REQ-019 DONE: o_done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-020 o_busy SHALL be 1 in CMP, SUB_A and SUB_B, and 0 in IDLE and DONE.
REQ-021 Latency: edge 0 is the edge that samples i_start. With k subtractions, o_done SHALL be high in the cycle after edge 2k+1.
REQ-022 i_start asserted while not in IDLE SHALL be ignored, with no queuing.
REQ-023 i_start in the DONE cycle SHALL be ignored; it is accepted from the next IDLE cycle.
REQ-024 q and o_iter SHALL hold their values from the end of a computation until the next accepted start.
REQ-025 o_iter SHALL saturate at all-ones and never wrap.
REQ-026 Subtraction results SHALL never underflow, because the larger operand is always the minuend.
REQ-027 gcd(0,0) SHALL return q=0 with o_iter=0.

Reset
REQ-028 While i_rst=1 at a rising edge, the block SHALL set state=IDLE, ra=0, rb=0, q=0, o_iter=0, o_done=0 and o_busy=0.
REQ-029 Reset asserted mid-computation SHALL abort the computation with no o_done pulse.
REQ-030 Reset SHALL take priority over i_start.

Structure
REQ-031 A shared package SHALL hold:
- the ALU operation codes (00, 10, 01, 11);
- the FSM state encoding.
REQ-032 The sole sub-module SHALL be one instance of the existing alu with N passed through.
REQ-033 The controller SHALL contain the operand registers, the equality/zero compares, the counter and the FSM.

Verification
REQ-034 a=12, b=8, start -> q=4, o_iter=2, o_done after edge 5, o_busy high edges 0..4.
REQ-035 a=7, b=7 -> q=7, o_iter=0, o_done after edge 1; a=0, b=9 -> q=9; a=0, b=0 -> q=0, both with o_iter=0.
REQ-036 a=21, b=6 -> q=3, o_iter=4, o_done after edge 9; a=65535, b=1 -> q=1, o_iter=65534.
REQ-037 Second start with a=5, b=5 pulsed during a busy 12/8 run -> ignored; result q=4, and exactly one o_done pulse.
REQ-038 i_rst at edge 3 of a 12/8 run -> all outputs 0 next cycle, no o_done; a following start with 9/6 -> q=3, o_iter=2.
REQ-039 Back-to-back: i_start held high continuously -> a new run begins in each IDLE cycle, and every o_done is exactly one cycle wide.
